// File: rtl/life_pkg.sv
// Shared types and constants for the 8x8 Game of Life generation engine.
package life_pkg;

  localparam int unsigned BOARD_DIM = 8;
  localparam int unsigned CELLS     = BOARD_DIM * BOARD_DIM;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT
  } state_t;

  // board[row][col]; bit col of a row byte is column col, 1 = alive
  typedef logic [BOARD_DIM-1:0][BOARD_DIM-1:0] board_t;

  function automatic logic [6:0] popcount8(input logic [7:0] v);
    logic [6:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {6'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/life_engine_cell_rule.sv
// Combinational Life rule for one cell: born on 3 neighbours, survives on 2 or 3.
module cell_rule
  import life_pkg::*;
(
  input  logic       i_center,
  input  logic [7:0] i_nbr,
  output logic       o_next
);

  logic [3:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < 8; i++) w_sum = w_sum + {3'b0, i_nbr[i]};
    o_next = (w_sum == 4'd3) || (i_center && (w_sum == 4'd2));
  end

endmodule

// File: rtl/life_engine.sv
// 8x8 Life engine: row loading, one-cell-per-clock generation into a shadow board, atomic commit.
// Build option: LIFE_TORUS_EN selects a toroidal board; otherwise edges read as dead.
module life_engine
  import life_pkg::*;
#(
  parameter int GEN_W = 8
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             load_en,
  input  logic [2:0]       load_row,
  input  logic [7:0]       load_data,
  input  logic             step,
  input  logic [5:0]       disp_addr,
  output logic [7:0]       row_out,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count,
  output logic [6:0]       alive_count,
  output logic             stable
);

  state_t           r_state;
  board_t           r_board;
  board_t           r_shadow;
  logic [7:0]       r_row_out;
  logic             r_busy;
  logic             r_done;
  logic [GEN_W-1:0] r_gen;
  logic [6:0]       r_alive;
  logic [6:0]       r_run;
  logic             r_stable;
  logic [5:0]       r_idx;

  logic [2:0] w_r, w_c, w_rn, w_rs, w_cw, w_ce;
  logic       w_n_ok, w_s_ok, w_w_ok, w_e_ok;
  logic [7:0] w_nbr;
  logic       w_next;
  logic       w_unused;

  assign w_unused = ^disp_addr[2:0];

  assign w_r  = r_idx[5:3];
  assign w_c  = r_idx[2:0];
  assign w_rn = w_r - 3'd1;
  assign w_rs = w_r + 3'd1;
  assign w_cw = w_c - 3'd1;
  assign w_ce = w_c + 3'd1;

`ifdef LIFE_TORUS_EN
  assign w_n_ok = 1'b1;
  assign w_s_ok = 1'b1;
  assign w_w_ok = 1'b1;
  assign w_e_ok = 1'b1;
`else
  assign w_n_ok = (w_r != 3'd0);
  assign w_s_ok = (w_r != 3'd7);
  assign w_w_ok = (w_c != 3'd0);
  assign w_e_ok = (w_c != 3'd7);
`endif

  // Wrapped indices are always in range; the ok flags mask them off on a bounded board.
  assign w_nbr = {
    w_n_ok & w_w_ok & r_board[w_rn][w_cw], w_n_ok & r_board[w_rn][w_c], w_n_ok & w_e_ok & r_board[w_rn][w_ce],
    w_w_ok & r_board[w_r][w_cw],                                        w_e_ok & r_board[w_r][w_ce],
    w_s_ok & w_w_ok & r_board[w_rs][w_cw], w_s_ok & r_board[w_rs][w_c], w_s_ok & w_e_ok & r_board[w_rs][w_ce]
  };

  cell_rule u_rule (
    .i_center (r_board[w_r][w_c]),
    .i_nbr    (w_nbr),
    .o_next   (w_next)
  );

  always_ff @(posedge ph1) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_board   <= '0;
      r_shadow  <= '0;
      r_row_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_gen     <= '0;
      r_alive   <= '0;
      r_run     <= '0;
      r_stable  <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_row_out <= r_board[disp_addr[5:3]];
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_en) begin
            r_board[load_row] <= load_data;
            r_gen             <= '0;
            r_stable          <= 1'b0;
            r_alive           <= r_alive + popcount8(load_data) - popcount8(r_board[load_row]);
          end else if (step) begin
            r_state <= COMPUTE;
            r_idx   <= '0;
            r_run   <= '0;
            r_busy  <= 1'b1;
          end
        end
        COMPUTE: begin
          r_shadow[w_r][w_c] <= w_next;
          r_run              <= r_run + {6'b0, w_next};
          if (r_idx == 6'(CELLS - 1)) begin
            r_state <= COMMIT;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        COMMIT: begin
          r_board  <= r_shadow;
          r_stable <= (r_shadow == r_board);
          r_alive  <= r_run;
          r_gen    <= r_gen + 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign row_out     = r_row_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign gen_count   = r_gen;
  assign alive_count = r_alive;
  assign stable      = r_stable;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine with a software Life model and an expected-value queue.
module tb_life_engine;

  localparam int GEN_W = 8;

  typedef logic [7:0][7:0] brd_t;
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic             ph1 = 1'b0;
  logic             reset = 1'b0;
  logic             load_en = 1'b0;
  logic [2:0]       load_row = '0;
  logic [7:0]       load_data = '0;
  logic             step = 1'b0;
  logic [5:0]       disp_addr = '0;
  logic [7:0]       row_out;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_count;
  logic [6:0]       alive_count;
  logic             stable;

  life_engine #(.GEN_W(GEN_W)) dut (
    .ph1         (ph1),
    .reset       (reset),
    .load_en     (load_en),
    .load_row    (load_row),
    .load_data   (load_data),
    .step        (step),
    .disp_addr   (disp_addr),
    .row_out     (row_out),
    .busy        (busy),
    .done        (done),
    .gen_count   (gen_count),
    .alive_count (alive_count),
    .stable      (stable)
  );

  always #5 ph1 = ~ph1;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  brd_t m_board = '0;
  int   m_gen = 0;

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic int popcnt(input brd_t b);
    int n = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (b[r][c]) n++;
    return n;
  endfunction

  function automatic brd_t life_model(input brd_t b);
    brd_t nb;
    int   n, rr, cc;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
`ifdef LIFE_TORUS_EN
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
              if (b[rr][cc]) n++;
`else
              if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                if (b[rr][cc]) n++;
              end
`endif
            end
          end
        end
        nb[r][c] = (n == 3) || (b[r][c] && n == 2);
      end
    end
    return nb;
  endfunction

  task automatic check_all_zero(input string pfx);
    push({pfx, "_row_out"}, 0);  pop_chk(32'(row_out));
    push({pfx, "_busy"}, 0);     pop_chk(32'(busy));
    push({pfx, "_done"}, 0);     pop_chk(32'(done));
    push({pfx, "_gen"}, 0);      pop_chk(32'(gen_count));
    push({pfx, "_alive"}, 0);    pop_chk(32'(alive_count));
    push({pfx, "_stable"}, 0);   pop_chk(32'(stable));
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    step = 1'b0;
    load_en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    m_board = '0;
    m_gen = 0;
  endtask

  task automatic read_row(input logic [2:0] r, input logic [7:0] expv, input string tag);
    disp_addr = {r, 3'b011};
    push(tag, 32'(expv));
    tick();
    pop_chk(32'(row_out));
  endtask

  task automatic check_rows();
    for (int r = 0; r < 8; r++) begin
      logic [2:0] rs;
      rs = 3'(r);
      read_row(rs, m_board[r], $sformatf("row%0d_gen%0d", r, m_gen));
    end
  endtask

  task automatic do_load(input logic [2:0] r, input logic [7:0] d);
    load_en = 1'b1;
    load_row = r;
    load_data = d;
    tick();
    load_en = 1'b0;
    m_board[r] = d;
    m_gen = 0;
    push("load_gen", 0);                  pop_chk(32'(gen_count));
    push("load_alive", popcnt(m_board));  pop_chk(32'(alive_count));
    push("load_stable", 0);               pop_chk(32'(stable));
  endtask

  // Step with the display parked on disp_row; checks busy/done timing and row_out latency.
  task automatic run_step(input logic [2:0] disp_row, input bit inject);
    brd_t old_b, new_b;
    int   cyc;
    old_b = m_board;
    new_b = life_model(m_board);
    disp_addr = {disp_row, 3'b101};
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 1;
    push("busy_first", 1);
    pop_chk(32'(busy));
    while (!done && cyc < 200) begin
      if (inject && cyc == 10) begin
        step = 1'b1;
        load_en = 1'b1;
        load_row = 3'd0;
        load_data = 8'hFF;
      end else begin
        step = 1'b0;
        load_en = 1'b0;
      end
      tick();
      cyc++;
    end
    push("done_cycle", 65);      pop_chk(32'(cyc));
    push("busy_commit", 1);      pop_chk(32'(busy));
    tick();
    push("done_pulse_end", 0);   pop_chk(32'(done));
    push("busy_idle", 0);        pop_chk(32'(busy));
    push("row_out_t66_old", 32'(old_b[disp_row])); pop_chk(32'(row_out));
    tick();
    push("row_out_t67_new", 32'(new_b[disp_row])); pop_chk(32'(row_out));
    m_board = new_b;
    m_gen++;
    push("gen", m_gen % (1 << GEN_W));         pop_chk(32'(gen_count));
    push("alive", popcnt(new_b));              pop_chk(32'(alive_count));
    push("stable", (new_b == old_b) ? 1 : 0);  pop_chk(32'(stable));
  endtask

  initial begin
    int cyc;
    tick();
    reset_dut();
    tick();
    check_all_zero("reset");

    // Blinker: oscillates horizontal <-> vertical
    do_load(3'd3, 8'b00011100);
    run_step(3'd2, 1'b0);
    read_row(3'd2, 8'b00001000, "blinker_r2");
    read_row(3'd3, 8'b00001000, "blinker_r3");
    read_row(3'd4, 8'b00001000, "blinker_r4");
    push("blinker_alive", 3); pop_chk(32'(alive_count));
    push("blinker_gen1", 1);  pop_chk(32'(gen_count));
    run_step(3'd3, 1'b0);
    read_row(3'd3, 8'b00011100, "blinker_back_r3");
    push("blinker_gen2", 2);  pop_chk(32'(gen_count));

    // Block still life
    reset_dut();
    do_load(3'd1, 8'b00000110);
    do_load(3'd2, 8'b00000110);
    run_step(3'd1, 1'b0);
    push("block_stable", 1);  pop_chk(32'(stable));
    push("block_alive", 4);   pop_chk(32'(alive_count));
    check_rows();

    // Glider heading into column 7
    reset_dut();
    do_load(3'd0, 8'b01000000);
    do_load(3'd1, 8'b10000000);
    do_load(3'd2, 8'b11100000);
    for (int s = 0; s < 4; s++) run_step(3'd2, 1'b0);
    check_rows();
`ifdef LIFE_TORUS_EN
    push("glider_alive_is5", 1);
`else
    push("glider_alive_is5", 0);
`endif
    pop_chk((alive_count == 7'd5) ? 32'd1 : 32'd0);

    // Requests during COMPUTE are dropped
    reset_dut();
    do_load(3'd3, 8'b00011100);
    run_step(3'd3, 1'b1);
    check_rows();

    // Simultaneous load and step in IDLE: load wins
    reset_dut();
    load_en = 1'b1;
    step = 1'b1;
    load_row = 3'd5;
    load_data = 8'hA5;
    tick();
    load_en = 1'b0;
    step = 1'b0;
    m_board[5] = 8'hA5;
    push("ls_busy0", 0);  pop_chk(32'(busy));
    tick();
    push("ls_busy1", 0);  pop_chk(32'(busy));
    push("ls_gen", 0);    pop_chk(32'(gen_count));
    push("ls_alive", 4);  pop_chk(32'(alive_count));
    read_row(3'd5, 8'hA5, "ls_row5");

    // Reset mid-COMPUTE aborts without committing
    reset_dut();
    do_load(3'd3, 8'b00011100);
    disp_addr = {3'd3, 3'b000};
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 1;
    while (cyc < 30) begin
      tick();
      cyc++;
    end
    push("mid_busy", 1);  pop_chk(32'(busy));
    reset = 1'b0;
    tick();
    check_all_zero("midreset");
    reset = 1'b1;
    m_board = '0;
    m_gen = 0;
    check_rows();
    run_step(3'd0, 1'b0);
    push("empty_alive", 0);   pop_chk(32'(alive_count));
    push("empty_stable", 1);  pop_chk(32'(stable));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
